// File: rtl/stream_trace_if.sv
// Stimulus fan-out (NUM_CH valid/ready channels) and response return between the trace harness and a DUT.
// The master side is the harness; the slave side is the DUT under test.
interface stream_trace_if #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]        stim_valid;
    logic [NUM_CH*DATA_W-1:0] stim_data;
    logic [NUM_CH-1:0]        stim_ready;
    logic                     resp_valid;
    logic [DATA_W-1:0]        resp_data;
    logic                     resp_ready;

    modport master (
        output stim_valid, stim_data, resp_ready,
        input  stim_ready, resp_valid, resp_data
    );

    modport slave (
        input  stim_valid, stim_data, resp_ready,
        output stim_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/stream_trace_harness.sv
// Replays preloaded per-channel stimulus traces into a DUT and scores its response stream against an expected trace.
// Valid/data are a same-cycle read of the trace memories, held while stalled; status lands one cycle after completion or watchdog expiry.
module stream_trace_harness #(
    parameter  int DATA_W  = 32,
    parameter  int NUM_CH  = 2,
    parameter  int DEPTH   = 256,
    parameter  int TIMEOUT = 1024,
    localparam int AW      = $clog2(DEPTH),
    localparam int SW      = $clog2(NUM_CH + 1),
    localparam int WW      = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [SW-1:0]     load_sel,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              len_en,
    input  logic [AW:0]       len_data,
    input  logic              start,
    stream_trace_if.master    bus,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       mismatch_count,
    output logic [AW:0]       first_mismatch_idx
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    localparam int              WD_LAST_I = TIMEOUT - 1;
    localparam logic [AW:0]     DEPTH_L   = DEPTH[AW:0];
    localparam logic [AW:0]     ONE_L     = {{AW{1'b0}}, 1'b1};
    localparam logic [WW-1:0]   WD_LAST   = WD_LAST_I[WW-1:0];
    localparam logic [WW-1:0]   WD_ONE    = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]   SEL_EXP   = NUM_CH[SW-1:0];

    state_e              state_q;
    logic [DATA_W-1:0]   smem_q [NUM_CH][DEPTH];
    logic [DATA_W-1:0]   emem_q [DEPTH];
    logic [AW:0]         slen_q [NUM_CH];
    logic [AW:0]         sptr_q [NUM_CH];
    logic [AW:0]         elen_q;
    logic [AW:0]         rptr_q;
    logic [WW-1:0]       wd_q;
    logic [15:0]         mcnt_q, mcnt_d;
    logic [AW:0]         fmi_q;
    logic                done_q, pass_q, timeout_q;

    logic                run, all_sent, extra, resp_hs, resp_mis, complete, wd_fire;
    logic [NUM_CH-1:0]   svld, shs;
    logic [NUM_CH*DATA_W-1:0] sdat;
    logic [AW:0]         len_clamp;

    always_comb begin
        run      = (state_q == S_RUN);
        all_sent = 1'b1;
        svld     = '0;
        shs      = '0;
        sdat     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            svld[c] = run && (sptr_q[c] < slen_q[c]);
            shs[c]  = svld[c] && bus.stim_ready[c];
            if (svld[c]) sdat[c*DATA_W +: DATA_W] = smem_q[c][sptr_q[c][AW-1:0]];
            if (sptr_q[c] != slen_q[c]) all_sent = 1'b0;
        end
        // Responses beyond the expected length always score as a mismatch.
        extra     = (rptr_q >= elen_q);
        resp_hs   = run && bus.resp_valid;
        resp_mis  = resp_hs && (extra || (bus.resp_data != emem_q[rptr_q[AW-1:0]]));
        mcnt_d    = mcnt_q;
        if (resp_mis && (mcnt_q != 16'hFFFF)) mcnt_d = mcnt_q + 16'd1;
        complete  = run && all_sent && extra;
        wd_fire   = run && (shs == '0) && !resp_hs && (wd_q == WD_LAST);
        len_clamp = (len_data > DEPTH_L) ? DEPTH_L : len_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            for (int c = 0; c < NUM_CH; c++) sptr_q[c] <= '0;
            rptr_q    <= '0;
            wd_q      <= '0;
            mcnt_q    <= '0;
            fmi_q     <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (shs[c]) sptr_q[c] <= sptr_q[c] + ONE_L;
                    end
                    if (resp_hs && (rptr_q != DEPTH_L)) rptr_q <= rptr_q + ONE_L;
                    if (resp_mis) begin
                        mcnt_q <= mcnt_d;
                        if (mcnt_q == '0) fmi_q <= extra ? DEPTH_L : rptr_q;
                    end
                    wd_q <= ((shs != '0) || resp_hs) ? '0 : wd_q + WD_ONE;
                    // Completion wins over a watchdog expiry in the same cycle.
                    if (complete) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (mcnt_d == '0);
                    end else if (wd_fire) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                default: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        for (int c = 0; c < NUM_CH; c++) sptr_q[c] <= '0;
                        rptr_q    <= '0;
                        wd_q      <= '0;
                        mcnt_q    <= '0;
                        fmi_q     <= '0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Trace memories and lengths survive reset; writes are locked out while a run is active.
    always_ff @(posedge clk) begin
        if (state_q != S_RUN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (load_en && (load_sel == SW'(c))) smem_q[c][load_addr] <= load_data;
                if (len_en && (load_sel == SW'(c)))  slen_q[c] <= len_clamp;
            end
            if (load_en && (load_sel == SEL_EXP)) emem_q[load_addr] <= load_data;
            if (len_en && (load_sel == SEL_EXP))  elen_q <= len_clamp;
        end
    end

    assign bus.stim_valid     = svld;
    assign bus.stim_data      = sdat;
    assign bus.resp_ready     = run;
    assign done               = done_q;
    assign pass               = pass_q;
    assign timeout            = timeout_q;
    assign mismatch_count     = mcnt_q;
    assign first_mismatch_idx = fmi_q;
endmodule

// File: doc/stream_trace_harness.md
Name: stream_trace_harness

Overview:
- Parametrised successor to the single-stream file-driven top-level harness.
- Replays preloaded stimulus on NUM_CH independent valid/ready source channels into a DUT.
- Sinks one DUT response stream and checks it against a preloaded expected trace.
- Reports done/pass, the mismatch count and the first failing index, and has an inactivity watchdog in place of end-of-file termination.

Parameters:
- DATA_W, 32, width of every stimulus/response word
- NUM_CH, 2, number of stimulus channels (1..8)
- DEPTH, 256, entries per trace memory (power of two); AW = $clog2(DEPTH)
- TIMEOUT, 1024, idle cycles in RUN before abort (>= 2)

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- load_en  in  1  write one trace word (honoured only in IDLE/DONE)
- load_sel  in  SW=$clog2(NUM_CH+1)  0..NUM_CH-1 selects a stimulus memory; NUM_CH selects the expected memory
- load_addr  in  AW  word address
- load_data  in  DATA_W  word
- len_en  in  1  write the length of the memory at load_sel (IDLE/DONE only)
- len_data  in  AW+1  length, 0..DEPTH; values > DEPTH clamp to DEPTH
- start  in  1  single-cycle pulse: IDLE/DONE -> RUN
- stim_valid  out  NUM_CH  per-channel valid
- stim_data  out  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- stim_ready  in  NUM_CH  DUT ready
- resp_valid  in  1  DUT response valid
- resp_data  in  DATA_W  DUT response word
- resp_ready  out  1  harness ready
- done  out  1  run finished (normal or timeout), held
- pass  out  1  valid when done
- timeout  out  1  watchdog fired
- mismatch_count  out  16  saturating at 16'hFFFF
- first_mismatch_idx  out  AW+1  response index of the first mismatch; DEPTH for an extra response

Behaviour:
- Reset (reset==0 at posedge):
  - FSM goes to IDLE; all pointers clear.
  - All outputs 0: stim_valid, stim_data, resp_ready, done, pass, timeout, mismatch_count, first_mismatch_idx.
  - Memory contents and lengths are not cleared.
  - Reset mid-RUN aborts immediately; the next cycle shows stim_valid=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --all complete--> DONE.
  - RUN --watchdog--> DONE.
  - DONE --start--> RUN. On this transition done, pass, timeout, mismatch_count and first_mismatch_idx clear and all pointers return to 0.
  - start in RUN is ignored. load_en/len_en in RUN are ignored.
- Stimulus, per channel c in RUN:
  - stim_valid[c] = (sptr[c] < slen[c]).
  - stim_data slice = smem[c][sptr[c]] (combinational read); stable while valid & !ready.
  - Handshake when stim_valid[c] & stim_ready[c] at posedge; sptr[c] increments by 1.
  - A channel with length 0 never asserts valid.
  - Channels are fully independent; simultaneous handshakes on all channels in one cycle are legal.
- Response:
  - resp_ready=1 in RUN only.
  - On resp_valid & resp_ready: if rptr < elen, compare resp_data with emem[rptr].
  - If rptr >= elen, the response is an extra response and counts as a mismatch with index DEPTH.
  - rptr increments and saturates at DEPTH.
  - On a mismatch, mismatch_count increments (saturating). first_mismatch_idx latches only on the first mismatch of a run.
- Completion: in RUN, when every sptr[c]==slen[c] and rptr>=elen at a posedge:
  - Next cycle: done=1, pass=(mismatch_count==0 including any mismatch in the same cycle), state DONE.
  - A run with all lengths 0 completes one cycle after start.
- Watchdog:
  - Counter clears on start and on any handshake (stimulus or response) in a cycle; otherwise it increments in RUN.
  - When it reaches TIMEOUT-1 without activity: next cycle done=1, timeout=1, pass=0, state DONE.
  - Completion takes priority over timeout in the same cycle.
- In DONE: stim_valid=0 and resp_ready=0; status outputs hold until start or reset.
- Load and length writes take effect at the posedge. A write with load_sel > NUM_CH is ignored.

Test Plan:
- NUM_CH=2, ch0 = {1,2,3}, ch1 = {0xA}, expected {5,6}, DUT ready=1, responds 5,6 -> ch0 accepts 3 words over 3 cycles; done=1 one cycle after the last handshake; pass=1; mismatch_count=0.
- Ready toggled 1-0-0-1 on ch0 -> stim_data stable while stalled; each word delivered exactly once, in order.
- Expected {5,6}, DUT sends 5,7,9 -> mismatch_count=2, first_mismatch_idx=1, pass=0; the extra response is counted.
- TIMEOUT=16, DUT holds stim_ready=0 -> timeout=1 and done=1 exactly 16 cycles after the last activity; pass=0.
- reset driven low for 1 cycle mid-RUN -> all outputs 0 the next cycle; state IDLE; a subsequent start replays from index 0 using the retained memories.
- load_en asserted during RUN with new data -> no change to the run; a second start after DONE clears status and reruns identically.
